// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: opcodes, access sizes and the
// EX/MEM pipeline bundle.
package mem_stage_pkg;

    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SB  = 6'b101000;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic {
        EXT_ZERO = 1'b0,
        EXT_SIGN = 1'b1
    } ext_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] aluAns;
        logic [31:0] grfRd2;
        logic        ifReGrf1;
        logic        ifReGrf2;
        logic        ifWrGrf;
        logic [4:0]  grfRa1;
        logic [4:0]  grfRa2;
        logic [4:0]  grfWa;
        logic [4:0]  tUseRs;
        logic [4:0]  tUseRt;
        logic [4:0]  tNew;
        logic [31:0] grfWd;
    } exMem_t;

endpackage

// File: rtl/mem_stage_dm.sv
// Word-organised data memory with byte/half/word write merge.
// Reads are combinational; writes land on the rising clock edge.
module dm
    import mem_stage_pkg::*;
#(
    parameter int DM_WORDS = 1024,
    parameter int DM_AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic [31:0] rdata
);

    logic [31:0]      mem [DM_WORDS];
    logic [DM_AW-1:0] index;
    logic [31:0]      merged;

    // Upper address bits are dropped, so out-of-range addresses wrap.
    assign index = addr[DM_AW+1:2];
    assign rdata = mem[index];

    always_comb begin
        merged = rdata;
        case (size)
            SZ_W: merged = wdata;
            SZ_H: begin
                if (addr[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            SZ_B: merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
            default: merged = rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[index] <= merged;
            $display("%d@%h: *%h <= %h", $time, pc,
                     {addr[31:2], 2'b00}, merged);
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, data memory access, load extension
// and hazard bookkeeping towards WB and the hazard unit.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DM_WORDS = 1024,
    parameter int DM_AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_ExToMem,
    input  logic [31:0] instr_ExToMem,
    input  logic [31:0] aluAns_ExToMem,
    input  logic [31:0] grfRd2_ExToMem,
    input  logic        ifReGrf1_ExToMem,
    input  logic        ifReGrf2_ExToMem,
    input  logic        ifWrGrf_ExToMem,
    input  logic [4:0]  grfRa1_ExToMem,
    input  logic [4:0]  grfRa2_ExToMem,
    input  logic [4:0]  grfWa_ExToMem,
    input  logic [4:0]  tUseRs_ExToMem,
    input  logic [4:0]  tUseRt_ExToMem,
    input  logic [4:0]  tNew_ExToMem,
    input  logic [31:0] grfWd_ExToMem,
    output logic [31:0] memFwd_Hz,
    output logic [4:0]  tNewMem_Hz,
    output logic [4:0]  grfWaMem_Hz,
    output logic        ifWrGrfMem_Hz,
    output logic [31:0] pc_MemToWb,
    output logic [31:0] instr_MemToWb,
    output logic        ifWrGrf_MemToWb,
    output logic [4:0]  grfWa_MemToWb,
    output logic [4:0]  tNew_MemToWb,
    output logic [31:0] grfWd_MemToWb
);

    exMem_t      q;
    logic        isLoad;
    logic        isStore;
    logic [1:0]  size;
    ext_e        ext;
    logic [31:0] rdata;
    logic [15:0] halfV;
    logic [7:0]  byteV;
    logic [31:0] loadVal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= '{
                pc:       pc_ExToMem,
                instr:    instr_ExToMem,
                aluAns:   aluAns_ExToMem,
                grfRd2:   grfRd2_ExToMem,
                ifReGrf1: ifReGrf1_ExToMem,
                ifReGrf2: ifReGrf2_ExToMem,
                ifWrGrf:  ifWrGrf_ExToMem,
                grfRa1:   grfRa1_ExToMem,
                grfRa2:   grfRa2_ExToMem,
                grfWa:    grfWa_ExToMem,
                tUseRs:   tUseRs_ExToMem,
                tUseRt:   tUseRt_ExToMem,
                tNew:     tNew_ExToMem,
                grfWd:    grfWd_ExToMem
            };
        end
    end

    always_comb begin
        isLoad  = 1'b0;
        isStore = 1'b0;
        size    = SZ_W;
        ext     = EXT_ZERO;
        case (q.instr[31:26])
            LW:  begin isLoad = 1'b1; size = SZ_W; end
            LH:  begin isLoad = 1'b1; size = SZ_H; ext = EXT_SIGN; end
            LHU: begin isLoad = 1'b1; size = SZ_H; end
            LB:  begin isLoad = 1'b1; size = SZ_B; ext = EXT_SIGN; end
            LBU: begin isLoad = 1'b1; size = SZ_B; end
            SW:  begin isStore = 1'b1; size = SZ_W; end
            SH:  begin isStore = 1'b1; size = SZ_H; end
            SB:  begin isStore = 1'b1; size = SZ_B; end
            default: ;
        endcase
    end

    dm #(
        .DM_WORDS(DM_WORDS),
        .DM_AW   (DM_AW)
    ) uDm (
        .clk  (clk),
        .reset(reset),
        .we   (isStore),
        .size (size),
        .addr (q.aluAns),
        .wdata(q.grfRd2),
        .pc   (q.pc),
        .rdata(rdata)
    );

    assign halfV = q.aluAns[1] ? rdata[31:16] : rdata[15:0];
    assign byteV = rdata[{q.aluAns[1:0], 3'b000} +: 8];

    always_comb begin
        loadVal = rdata;
        if (isLoad) begin
            case (size)
                SZ_H: loadVal = (ext == EXT_SIGN)
                              ? {{16{halfV[15]}}, halfV}
                              : {16'h0000, halfV};
                SZ_B: loadVal = (ext == EXT_SIGN)
                              ? {{24{byteV[7]}}, byteV}
                              : {24'h000000, byteV};
                default: loadVal = rdata;
            endcase
        end
    end

    always_comb begin
        case (q.tNew)
            5'd0:    grfWd_MemToWb = q.grfWd;
            5'd1:    grfWd_MemToWb = loadVal;
            default: grfWd_MemToWb = 32'h0;
        endcase
    end

    assign tNew_MemToWb    = (q.tNew == 5'd0) ? 5'd0 : q.tNew - 5'd1;
    assign memFwd_Hz       = q.grfWd;
    assign tNewMem_Hz      = q.tNew;
    assign grfWaMem_Hz     = q.grfWa;
    assign ifWrGrfMem_Hz   = q.ifWrGrf;
    assign pc_MemToWb      = q.pc;
    assign instr_MemToWb   = q.instr;
    assign ifWrGrf_MemToWb = q.ifWrGrf;
    assign grfWa_MemToWb   = q.grfWa;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table plus reset sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, instr, aluAns, rd2, wdIn;
    logic        re1, re2, wr;
    logic [4:0]  ra1, ra2, wa, tUseRs, tUseRt, tNewIn;
    logic [31:0] memFwd, pcWb, instrWb, wdWb;
    logic [4:0]  tNewMem, waMem, waWb, tNewWb;
    logic        wrMem, wrWb;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .pc_ExToMem      (pc),
        .instr_ExToMem   (instr),
        .aluAns_ExToMem  (aluAns),
        .grfRd2_ExToMem  (rd2),
        .ifReGrf1_ExToMem(re1),
        .ifReGrf2_ExToMem(re2),
        .ifWrGrf_ExToMem (wr),
        .grfRa1_ExToMem  (ra1),
        .grfRa2_ExToMem  (ra2),
        .grfWa_ExToMem   (wa),
        .tUseRs_ExToMem  (tUseRs),
        .tUseRt_ExToMem  (tUseRt),
        .tNew_ExToMem    (tNewIn),
        .grfWd_ExToMem   (wdIn),
        .memFwd_Hz       (memFwd),
        .tNewMem_Hz      (tNewMem),
        .grfWaMem_Hz     (waMem),
        .ifWrGrfMem_Hz   (wrMem),
        .pc_MemToWb      (pcWb),
        .instr_MemToWb   (instrWb),
        .ifWrGrf_MemToWb (wrWb),
        .grfWa_MemToWb   (waWb),
        .tNew_MemToWb    (tNewWb),
        .grfWd_MemToWb   (wdWb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [31:0] wd;
        logic [4:0]  tNew;
        logic [4:0]  wa;
        logic        wr;
        logic [31:0] expWd;
        logic [4:0]  expTNew;
    } vec_t;

    vec_t vecs[$];

    task automatic check32(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(logic [31:0] p, logic [5:0] op, logic [31:0] a,
                         logic [31:0] d, logic [31:0] w, logic [4:0] t,
                         logic [4:0] r, logic wflag);
        pc     = p;
        instr  = {op, 26'h0012345};
        aluAns = a;
        rd2    = d;
        wdIn   = w;
        tNewIn = t;
        wa     = r;
        wr     = wflag;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(string nm);
        check32({nm, ".memFwd"}, memFwd, 32'h0);
        check32({nm, ".pc"}, pcWb, 32'h0);
        check32({nm, ".instr"}, instrWb, 32'h0);
        check32({nm, ".wd"}, wdWb, 32'h0);
        check32({nm, ".tNew"}, {27'h0, tNewWb}, 32'h0);
        check32({nm, ".tNewMem"}, {27'h0, tNewMem}, 32'h0);
        check32({nm, ".wa"}, {27'h0, waWb}, 32'h0);
        check32({nm, ".waMem"}, {27'h0, waMem}, 32'h0);
        check32({nm, ".wr"}, {31'h0, wrWb}, 32'h0);
        check32({nm, ".wrMem"}, {31'h0, wrMem}, 32'h0);
    endtask

    function automatic vec_t mk(string n, logic [5:0] op, logic [31:0] a,
                                logic [31:0] d, logic [31:0] w,
                                logic [4:0] t, logic [4:0] r, logic f,
                                logic [31:0] ew, logic [4:0] et);
        vec_t v;
        v.name = n; v.op = op; v.alu = a; v.rd2 = d; v.wd = w;
        v.tNew = t; v.wa = r; v.wr = f; v.expWd = ew; v.expTNew = et;
        return v;
    endfunction

    initial begin
        vecs.push_back(mk("sw10", 6'h2b, 32'h10, 32'h12345678, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lw10", 6'h23, 32'h10, 0, 0, 1, 3, 1, 32'h12345678, 0));
        vecs.push_back(mk("sb13", 6'h28, 32'h13, 32'h000000ab, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lw10b", 6'h23, 32'h10, 0, 0, 1, 4, 1, 32'hab345678, 0));
        vecs.push_back(mk("sh10", 6'h29, 32'h10, 32'h0000beef, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lw10h", 6'h23, 32'h10, 0, 0, 1, 5, 1, 32'hab34beef, 0));
        vecs.push_back(mk("sw20", 6'h2b, 32'h20, 32'h80ff7f80, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lb20", 6'h20, 32'h20, 0, 0, 1, 6, 1, 32'hffffff80, 0));
        vecs.push_back(mk("lbu20", 6'h24, 32'h20, 0, 0, 1, 6, 1, 32'h00000080, 0));
        vecs.push_back(mk("lh22", 6'h21, 32'h22, 0, 0, 1, 7, 1, 32'hffff80ff, 0));
        vecs.push_back(mk("lhu22", 6'h25, 32'h22, 0, 0, 1, 7, 1, 32'h000080ff, 0));
        vecs.push_back(mk("lw23", 6'h23, 32'h23, 0, 0, 1, 7, 1, 32'h80ff7f80, 0));
        vecs.push_back(mk("lb21", 6'h20, 32'h21, 0, 0, 1, 9, 1, 32'h0000007f, 0));
        vecs.push_back(mk("lh20", 6'h21, 32'h20, 0, 0, 1, 9, 1, 32'h00007f80, 0));
        vecs.push_back(mk("lbu23", 6'h24, 32'h23, 0, 0, 1, 9, 1, 32'h00000080, 0));
        vecs.push_back(mk("addu", 6'h00, 32'h10, 32'hffffffff, 5, 0, 8, 1, 5, 0));
        vecs.push_back(mk("lwAfterAlu", 6'h23, 32'h10, 0, 0, 1, 2, 1, 32'hab34beef, 0));
        vecs.push_back(mk("lwT2", 6'h23, 32'h20, 0, 32'h77, 2, 2, 1, 0, 1));
        vecs.push_back(mk("tNew3", 6'h00, 32'h0, 0, 32'h99, 3, 1, 1, 0, 2));
        vecs.push_back(mk("sw40", 6'h2b, 32'h40, 32'hdeadbeef, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lw40", 6'h23, 32'h40, 0, 0, 1, 10, 1, 32'hdeadbeef, 0));
        vecs.push_back(mk("lw1040", 6'h23, 32'h1040, 0, 0, 1, 10, 1, 32'hdeadbeef, 0));
        vecs.push_back(mk("sw1044", 6'h2b, 32'h1044, 32'hcafe0001, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lw44", 6'h23, 32'h44, 0, 0, 1, 11, 1, 32'hcafe0001, 0));
        vecs.push_back(mk("bubble", 6'h00, 0, 0, 0, 0, 0, 0, 0, 0));

        reset = 1'b1;
        pc = 0; instr = 0; aluAns = 0; rd2 = 0; wdIn = 0; wr = 0;
        re1 = 1'b1; re2 = 1'b1; ra1 = 5'd1; ra2 = 5'd2; wa = 0;
        tUseRs = 5'd1; tUseRt = 5'd2; tNewIn = 0;
        @(posedge clk);
        #1;
        checkAllZero("reset0");
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            logic [31:0] p;
            p = 32'h3000 + 32'(i) * 4;
            issue(p, vecs[i].op, vecs[i].alu, vecs[i].rd2, vecs[i].wd,
                  vecs[i].tNew, vecs[i].wa, vecs[i].wr);
            check32({vecs[i].name, ".wd"}, wdWb, vecs[i].expWd);
            check32({vecs[i].name, ".tNew"}, {27'h0, tNewWb},
                    {27'h0, vecs[i].expTNew});
            check32({vecs[i].name, ".memFwd"}, memFwd, vecs[i].wd);
            check32({vecs[i].name, ".tNewMem"}, {27'h0, tNewMem},
                    {27'h0, vecs[i].tNew});
            check32({vecs[i].name, ".waMem"}, {27'h0, waMem},
                    {27'h0, vecs[i].wa});
            check32({vecs[i].name, ".waWb"}, {27'h0, waWb},
                    {27'h0, vecs[i].wa});
            check32({vecs[i].name, ".wrMem"}, {31'h0, wrMem},
                    {31'h0, vecs[i].wr});
            check32({vecs[i].name, ".wrWb"}, {31'h0, wrWb},
                    {31'h0, vecs[i].wr});
            check32({vecs[i].name, ".pc"}, pcWb, p);
            check32({vecs[i].name, ".instr"}, instrWb,
                    {vecs[i].op, 26'h0012345});
        end

        // Pending store to 0x50 sits in MEM when reset hits mid-cycle.
        issue(32'h4000, 6'h2b, 32'h50, 32'h11111111, 32'h55, 0, 12, 1);
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("asyncReset");
        @(negedge clk);
        reset = 1'b0;
        issue(32'h4004, 6'h23, 32'h50, 0, 0, 1, 1, 1);
        check32("abortedStore", wdWb, 32'h0);
        issue(32'h4008, 6'h23, 32'h0, 0, 0, 1, 1, 1);
        check32("lw0AfterReset", wdWb, 32'h0);
        issue(32'h400c, 6'h23, 32'h40, 0, 0, 1, 1, 1);
        check32("lw40AfterReset", wdWb, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
